eth_axis_rx_frame_classifier: RTL

Consumes the 64-bit AXI-Stream TX frame stream produced by the fake transmitter (or by the real MAC TX path) and parses it beat by beat. It measures frame length and checks tkeep legality, then classifies each frame as ARP, ICMP, UDP, other IPv4 or other. It reports one registered result per frame and keeps per-class counters for bench scoreboarding and on-chip debug.

---
 rtl/eth_axis_rx_frame_classifier.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_axis_rx_frame_classifier.sv
// ---------------------------------------------------------------------------
// eth_axis_rx_frame_classifier
//
// Purpose:
//   Parses a 64-bit AXI-Stream Ethernet frame stream beat by beat. It measures
//   the frame length, checks tkeep legality and classifies each frame as
//   ARP / ICMP / UDP / other IPv4 / other. It emits one registered result per
//   frame and keeps per-class statistics counters.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_rx_axis_tvalid          beat valid (always accepted, no tready)
//   i_rx_axis_tdata[63:0]     beat data, wire byte k = tdata[8k+7:8k]
//   i_rx_axis_tlast           last beat of frame
//   i_rx_axis_tkeep[7:0]      byte enables, LSB-aligned contiguous
//   o_frame_valid             one-cycle result strobe, the cycle after tlast
//   o_frame_type[2:0]         0 OTHER, 1 ARP, 2 ICMP, 3 UDP, 4 IPV4_OTHER
//   o_frame_len[15:0]         frame byte count, saturating at 16'hFFFF
//   o_frame_err               tkeep / runt / oversize error
//   o_dst_match               dst MAC is LOCAL_MAC or broadcast
//   o_cnt_*                   wrapping statistics counters
//
// Build option:
//   ETH_RX_MAC_FILTER_EN  when defined, frames whose dst MAC does not match
//                         produce no strobe, no counter update, and leave the
//                         held result registers unchanged.
// ---------------------------------------------------------------------------
module eth_axis_rx_frame_classifier #(
  parameter logic [47:0] LOCAL_MAC       = 48'h211abcdef112,
  parameter int          MIN_FRAME_BYTES = 14,
  parameter int          MAX_FRAME_BYTES = 1518,
  parameter int          CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_rx_axis_tvalid,
  input  logic [63:0]      i_rx_axis_tdata,
  input  logic             i_rx_axis_tlast,
  input  logic [7:0]       i_rx_axis_tkeep,
  output logic             o_frame_valid,
  output logic [2:0]       o_frame_type,
  output logic [15:0]      o_frame_len,
  output logic             o_frame_err,
  output logic             o_dst_match,
  output logic [CNT_W-1:0] o_cnt_arp,
  output logic [CNT_W-1:0] o_cnt_icmp,
  output logic [CNT_W-1:0] o_cnt_udp,
  output logic [CNT_W-1:0] o_cnt_other,
  output logic [CNT_W-1:0] o_cnt_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  localparam logic [2:0] TYPE_OTHER      = 3'd0;
  localparam logic [2:0] TYPE_ARP        = 3'd1;
  localparam logic [2:0] TYPE_ICMP       = 3'd2;
  localparam logic [2:0] TYPE_UDP        = 3'd3;
  localparam logic [2:0] TYPE_IPV4_OTHER = 3'd4;

  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_BYTES);
  localparam logic [16:0] MAX_LEN = 17'(MAX_FRAME_BYTES);

  // Bytes outside tkeep are treated as not received, so header fields that
  // fall in a disabled byte lane read as 0.
  logic [63:0] data_m;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign data_m[8*gi +: 8] = i_rx_axis_tkeep[gi] ? i_rx_axis_tdata[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Byte lane 6 never carries a header field this block looks at.
  logic unused_lane6;
  assign unused_lane6 = ^data_m[55:48];

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  // Parser state and per-frame accumulators
  logic [1:0]  state_q, state_d;
  logic        hdr_idx_q, hdr_idx_d;   // 0: next HDR beat is beat 1, 1: beat 2
  logic [16:0] len_acc_q, len_acc_d;
  logic        err_acc_q, err_acc_d;
  logic [47:0] dst_acc_q, dst_acc_d;
  logic [15:0] etype_acc_q, etype_acc_d;
  logic [7:0]  proto_acc_q, proto_acc_d;

  // Held result and counters
  logic             valid_q;
  logic [2:0]       type_q;
  logic [15:0]      len_q;
  logic             err_q;
  logic             dm_q;
  logic [CNT_W-1:0] cnt_arp_q, cnt_icmp_q, cnt_udp_q, cnt_other_q, cnt_err_q;

  // Frame-so-far values including the current beat
  logic        beat0;
  logic [16:0] cur_len;
  logic        cur_err;
  logic [47:0] cur_dst;
  logic [15:0] cur_etype;
  logic [7:0]  cur_proto;
  logic [17:0] len_sum;
  logic [4:0]  beat_bytes;
  logic        beat_err;
  logic        fin_err;
  logic        fin_dm;
  logic [2:0]  fin_type;
  logic [15:0] fin_len;
  logic        frame_done;
  logic        frame_pass;

  always_comb begin
    // Beat 0 starts a fresh frame; stale accumulators are ignored.
    beat0 = (state_q == ST_IDLE);

    cur_dst = beat0 ? {data_m[7:0],   data_m[15:8],  data_m[23:16],
                       data_m[31:24], data_m[39:32], data_m[47:40]}
                    : dst_acc_q;

    cur_etype = beat0 ? 16'h0000 : etype_acc_q;
    if (state_q == ST_HDR && !hdr_idx_q) cur_etype = {data_m[39:32], data_m[47:40]};

    cur_proto = beat0 ? 8'h00 : proto_acc_q;
    if (state_q == ST_HDR && hdr_idx_q) cur_proto = data_m[63:56];

    // Non-last beats always count 8 bytes; illegal tkeep is reported as error.
    beat_bytes = i_rx_axis_tlast ? {1'b0, popcount8(i_rx_axis_tkeep)} : 5'd8;
    len_sum    = {1'b0, (beat0 ? 17'd0 : len_acc_q)} + {13'd0, beat_bytes};
    cur_len    = len_sum[17] ? 17'h1FFFF : len_sum[16:0];

    // A legal last-beat tkeep has the form 2^n-1 with n >= 1.
    if (i_rx_axis_tlast)
      beat_err = (i_rx_axis_tkeep == 8'h00) ||
                 ((i_rx_axis_tkeep & (i_rx_axis_tkeep + 8'd1)) != 8'h00);
    else
      beat_err = (i_rx_axis_tkeep != 8'hFF);
    cur_err = (beat0 ? 1'b0 : err_acc_q) | beat_err;

    fin_err = cur_err || (cur_len < MIN_LEN) || (cur_len > MAX_LEN);
    fin_dm  = (cur_dst == LOCAL_MAC) || (cur_dst == 48'hFFFF_FFFF_FFFF);
    fin_len = cur_len[16] ? 16'hFFFF : cur_len[15:0];

    if (fin_err)                    fin_type = TYPE_OTHER;
    else if (cur_etype == 16'h0806) fin_type = TYPE_ARP;
    else if (cur_etype == 16'h0800) begin
      if (cur_proto == 8'h01)       fin_type = TYPE_ICMP;
      else if (cur_proto == 8'h11)  fin_type = TYPE_UDP;
      else                          fin_type = TYPE_IPV4_OTHER;
    end
    else                            fin_type = TYPE_OTHER;

    frame_done = i_rx_axis_tvalid && i_rx_axis_tlast;

    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    len_acc_d   = len_acc_q;
    err_acc_d   = err_acc_q;
    dst_acc_d   = dst_acc_q;
    etype_acc_d = etype_acc_q;
    proto_acc_d = proto_acc_q;

    if (i_rx_axis_tvalid) begin
      len_acc_d   = cur_len;
      err_acc_d   = cur_err;
      dst_acc_d   = cur_dst;
      etype_acc_d = cur_etype;
      proto_acc_d = cur_proto;
      if (i_rx_axis_tlast) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d   = ST_HDR;
            hdr_idx_d = 1'b0;
          end
          ST_HDR: begin
            if (hdr_idx_q) state_d = ST_BODY;
            else           hdr_idx_d = 1'b1;
          end
          ST_BODY: state_d = ST_BODY;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

`ifdef ETH_RX_MAC_FILTER_EN
  assign frame_pass = fin_dm;
`else
  assign frame_pass = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= 1'b0;
      len_acc_q   <= '0;
      err_acc_q   <= 1'b0;
      dst_acc_q   <= '0;
      etype_acc_q <= '0;
      proto_acc_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      len_acc_q   <= len_acc_d;
      err_acc_q   <= err_acc_d;
      dst_acc_q   <= dst_acc_d;
      etype_acc_q <= etype_acc_d;
      proto_acc_q <= proto_acc_d;
    end
  end

  // Result registers are loaded straight from the tlast beat, so a new frame
  // starting in the strobe cycle only touches the accumulators above.
  // Counters load on the same edge, so they already include the frame while
  // its strobe is high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q     <= 1'b0;
      type_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      dm_q        <= 1'b0;
      cnt_arp_q   <= '0;
      cnt_icmp_q  <= '0;
      cnt_udp_q   <= '0;
      cnt_other_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (frame_done && frame_pass) begin
        valid_q <= 1'b1;
        type_q  <= fin_type;
        len_q   <= fin_len;
        err_q   <= fin_err;
        dm_q    <= fin_dm;
        if (fin_err)                 cnt_err_q   <= cnt_err_q + CNT_W'(1);
        else if (fin_type == TYPE_ARP)  cnt_arp_q  <= cnt_arp_q + CNT_W'(1);
        else if (fin_type == TYPE_ICMP) cnt_icmp_q <= cnt_icmp_q + CNT_W'(1);
        else if (fin_type == TYPE_UDP)  cnt_udp_q  <= cnt_udp_q + CNT_W'(1);
        else                            cnt_other_q <= cnt_other_q + CNT_W'(1);
      end
    end
  end

  assign o_frame_valid = valid_q;
  assign o_frame_type  = type_q;
  assign o_frame_len   = len_q;
  assign o_frame_err   = err_q;
  assign o_dst_match   = dm_q;
  assign o_cnt_arp     = cnt_arp_q;
  assign o_cnt_icmp    = cnt_icmp_q;
  assign o_cnt_udp     = cnt_udp_q;
  assign o_cnt_other   = cnt_other_q;
  assign o_cnt_err     = cnt_err_q;

endmodule
